// File: rtl/mips_pkg.sv
// Shared types and widths for the instruction-fetch control slice.
package mips_pkg;

  localparam int PC_W    = 32;
  localparam int INDEX_W = 26;
  localparam int IMM_W   = 16;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_ERROR = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_control_if.sv
// Signal bundle between the fetch controller and its decoder / instruction memory.
interface pc_fetch_control_if;
  import mips_pkg::*;

  logic               stall;
  logic               branch;
  logic               zero;
  logic               jump;
  logic [PC_W-1:0]    imm_ext;
  logic [INDEX_W-1:0] instr_index;
  logic               imem_ready;

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus4;
  logic [PC_W-1:0]    branch_target;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               instr_valid;
  logic               fetch_err;
  logic [PC_W-1:0]    retired;
  fetch_state_t       fsm_state;

  // Fetch handshake: a fetch completes on the rising edge where imem_req and
  // imem_ready are both 1; imem_ready is a don't-care whenever imem_req is 0.
  modport master (
    input  stall, branch, zero, jump, imm_ext, instr_index, imem_ready,
    output pc, pc_plus4, branch_target, imem_req, imem_addr,
           instr_valid, fetch_err, retired, fsm_state
  );

  modport slave (
    output stall, branch, zero, jump, imm_ext, instr_index, imem_ready,
    input  pc, pc_plus4, branch_target, imem_req, imem_addr,
           instr_valid, fetch_err, retired, fsm_state
  );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential, conditional branch, or jump.
module pc_next_logic
  import mips_pkg::*;
(
  input  logic [PC_W-1:0]    pc,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  input  logic [PC_W-1:0]    imm_ext,
  input  logic [INDEX_W-1:0] instr_index,
  output logic [PC_W-1:0]    pc_plus4,
  output logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    next_pc
);

  // Wrapping 32-bit adds give modulo arithmetic and backward branches for free.
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {imm_ext[PC_W-3:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[PC_W-1:PC_W-4], instr_index, 2'b00};
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/pc_fetch_control.sv
// PC register, retired counter and FETCH/EXEC/ERROR sequencing with a fetch timeout.
module pc_fetch_control
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int              MEM_TIMEOUT = 8
) (
  input  logic               clock,
  input  logic               reset,
  pc_fetch_control_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  fetch_state_t     state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt, wait_inc;
  logic [PC_W-1:0]  pc_q, retired_q, next_pc, pc_plus4, branch_target;
  logic             advance;

  pc_next_logic u_next (
    .pc            (pc_q),
    .branch        (bus.branch),
    .zero          (bus.zero),
    .jump          (bus.jump),
    .imm_ext       (bus.imm_ext),
    .instr_index   (bus.instr_index),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .next_pc       (next_pc)
  );

  assign wait_inc = wait_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    advance   = 1'b0;
    unique case (state)
      ST_FETCH: begin
        if (bus.imem_ready) begin
          state_nxt = ST_EXEC;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_inc;
          if (wait_inc == CNT_W'(MEM_TIMEOUT)) state_nxt = ST_ERROR;
        end
      end
      ST_EXEC: begin
        // Decoder controls only matter on the cycle the instruction completes.
        if (!bus.stall) begin
          state_nxt = ST_FETCH;
          wait_nxt  = '0;
          advance   = 1'b1;
        end
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_FETCH;
      wait_cnt  <= '0;
      pc_q      <= RESET_PC;
      retired_q <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (advance) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  // Status outputs decode straight from state so reset clears them without a clock.
  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.branch_target = branch_target;
  assign bus.imem_addr     = pc_q;
  assign bus.imem_req      = (state == ST_FETCH);
  assign bus.instr_valid   = (state == ST_EXEC);
  assign bus.fetch_err     = (state == ST_ERROR);
  assign bus.retired       = retired_q;
  assign bus.fsm_state     = state;

endmodule

// File: tb/tb_pc_fetch_control.sv
// Directed and randomized checks of PC sequencing, stall, timeout and reset.
module tb_pc_fetch_control;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam int          TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pc_fetch_control_if bus();

  pc_fetch_control #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_retired;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic br,
                                             input logic z, input logic j,
                                             input logic [31:0] imm, input logic [25:0] idx);
    logic [31:0] p4;
    p4 = cur + 32'd4;
    if (j) return {p4[31:28], idx, 2'b00};
    if (br && z) return p4 + (imm << 2);
    return p4;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble();
    bus.branch      = 1'($urandom_range(0, 1));
    bus.zero        = 1'($urandom_range(0, 1));
    bus.jump        = 1'($urandom_range(0, 1));
    bus.imm_ext     = $urandom;
    bus.instr_index = 26'($urandom);
  endtask

  task automatic clear_inputs();
    bus.stall       = 1'b0;
    bus.branch      = 1'b0;
    bus.zero        = 1'b0;
    bus.jump        = 1'b0;
    bus.imm_ext     = '0;
    bus.instr_index = '0;
    bus.imem_ready  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_pc      = RST_PC;
    model_retired = '0;
    exp_q.delete();
  endtask

  // Drives one instruction from FETCH to the next FETCH; pushes the expected PC.
  task automatic run_instr(input logic br, input logic z, input logic j,
                           input logic [31:0] imm, input logic [25:0] idx,
                           input int latency, input int stalls);
    bus.stall      = 1'b0;
    bus.imem_ready = 1'b0;
    for (int i = 0; i < latency; i++) begin
      scramble();
      step();
    end
    bus.imem_ready = 1'b1;
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      scramble();
      bus.imem_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.stall       = 1'b0;
    bus.branch      = br;
    bus.zero        = z;
    bus.jump        = j;
    bus.imm_ext     = imm;
    bus.instr_index = idx;
    exp_q.push_back(model_next(model_pc, br, z, j, imm, idx));
    model_pc      = model_next(model_pc, br, z, j, imm, idx);
    model_retired = model_retired + 32'd1;
    step();
    bus.imem_ready = 1'b0;
    scramble();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    n_vec++;
    if (bus.pc !== RST_PC || bus.retired !== 32'd0) begin
      n_err++;
      $display("FAIL reset_regs: pc=%h retired=%h expected pc=%h retired=0", bus.pc, bus.retired, RST_PC);
    end
    n_vec++;
    if (bus.instr_valid !== 1'b0 || bus.fetch_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: instr_valid=%b fetch_err=%b expected 0 0", bus.instr_valid, bus.fetch_err);
    end
    reset = 1'b0;
    model_pc      = RST_PC;
    model_retired = '0;
    n_vec++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
      n_err++;
      $display("FAIL reset_release: imem_req=%b imem_addr=%h expected 1 %h", bus.imem_req, bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL seq_fetch: req=%b valid=%b addr=%h expected 1 0 %h", bus.imem_req, bus.instr_valid, bus.imem_addr, 32'(4 * k));
      end
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      n_vec++;
      if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL seq_exec: valid=%b req=%b expected 1 0", bus.instr_valid, bus.imem_req);
      end
      exp_q.push_back(32'(4 * (k + 1)));
      model_pc      = 32'(4 * (k + 1));
      model_retired = model_retired + 32'd1;
      step();
      exp_pc = exp_q.pop_front();
      n_vec++;
      if (bus.pc !== exp_pc) begin
        n_err++;
        $display("FAIL seq_pc: got %h expected %h", bus.pc, exp_pc);
      end
    end
    n_vec++;
    if (bus.retired !== 32'd3) begin
      n_err++;
      $display("FAIL seq_retired: got %0d expected 3", bus.retired);
    end
  endtask

  task automatic test_branch_back();
    logic [31:0] exp_pc;
    run_instr(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 0, 0);
    exp_pc = exp_q.pop_front();
    n_vec++;
    if (bus.pc !== exp_pc || bus.pc !== 32'h0000_0010) begin
      n_err++;
      $display("FAIL pc_reach_10: got %h expected 00000010", bus.pc);
    end
    run_instr(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0, 1, 0);
    exp_pc = exp_q.pop_front();
    n_vec++;
    if (bus.pc !== exp_pc || bus.pc !== 32'h0000_000C) begin
      n_err++;
      $display("FAIL branch_back: got %h expected 0000000c", bus.pc);
    end
  endtask

  task automatic test_jump_priority();
    logic [31:0] exp_pc, imm;
    imm = (32'h4000_0000 - (model_pc + 32'd4)) >> 2;
    run_instr(1'b1, 1'b1, 1'b0, imm, 26'h0, 2, 0);
    exp_pc = exp_q.pop_front();
    n_vec++;
    if (bus.pc !== exp_pc || bus.pc !== 32'h4000_0000) begin
      n_err++;
      $display("FAIL branch_far: got %h expected 40000000", bus.pc);
    end
    run_instr(1'b1, 1'b1, 1'b1, 32'h0000_0010, 26'h0000100, 2, 0);
    exp_pc = exp_q.pop_front();
    n_vec++;
    if (bus.pc !== exp_pc || bus.pc !== 32'h4000_0400) begin
      n_err++;
      $display("FAIL jump_priority: got %h expected 40000400", bus.pc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    bus.stall      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (bus.pc !== model_pc || bus.instr_valid !== 1'b1 || bus.retired !== model_retired) begin
        n_err++;
        $display("FAIL stall_hold: pc=%h valid=%b retired=%0d expected %h 1 %0d", bus.pc, bus.instr_valid, bus.retired, model_pc, model_retired);
      end
      scramble();
      bus.imem_ready = 1'($urandom_range(0, 1));
      step();
    end
    clear_inputs();
    exp_q.push_back(model_pc + 32'd4);
    model_pc      = model_pc + 32'd4;
    model_retired = model_retired + 32'd1;
    step();
    exp_pc = exp_q.pop_front();
    n_vec++;
    if (bus.pc !== exp_pc || bus.retired !== model_retired) begin
      n_err++;
      $display("FAIL stall_release: pc=%h retired=%0d expected %h %0d", bus.pc, bus.retired, exp_pc, model_retired);
    end
    n_vec++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL stall_refetch: valid=%b req=%b expected 0 1", bus.instr_valid, bus.imem_req);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc, imm;
    imm = (32'hFFFF_FFFC - (model_pc + 32'd4)) >> 2;
    run_instr(1'b1, 1'b1, 1'b0, imm, 26'h0, 0, 1);
    exp_pc = exp_q.pop_front();
    n_vec++;
    if (bus.pc !== exp_pc || bus.pc !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_setup: got %h expected fffffffc", bus.pc);
    end
    n_vec++;
    if (bus.pc_plus4 !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL wrap_plus4: got %h expected 00000000", bus.pc_plus4);
    end
    bus.imm_ext = 32'hFFFF_FFFF;
    #1;
    n_vec++;
    if (bus.branch_target !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_target: got %h expected fffffffc", bus.branch_target);
    end
    run_instr(1'b0, 1'b1, 1'b0, 32'h0, 26'h0, 1, 0);
    exp_pc = exp_q.pop_front();
    n_vec++;
    if (bus.pc !== exp_pc || bus.pc !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL wrap_pc: got %h expected 00000000", bus.pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, imm;
    logic        br, z, j;
    for (int n = 0; n < 30; n++) begin
      br  = 1'($urandom_range(0, 1));
      z   = 1'($urandom_range(0, 1));
      j   = ($urandom_range(0, 3) == 0);
      imm = 32'($signed(16'($urandom)));
      run_instr(br, z, j, imm, 26'($urandom), $urandom_range(0, 4), $urandom_range(0, 3));
      exp_pc = exp_q.pop_front();
      n_vec++;
      if (bus.pc !== exp_pc || bus.retired !== model_retired) begin
        n_err++;
        $display("FAIL random_%0d: pc=%h retired=%0d expected %h %0d", n, bus.pc, bus.retired, exp_pc, model_retired);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_instr(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 0, 0);
      exp_pc = exp_q.pop_front();
      n_vec++;
      if (bus.pc !== exp_pc) begin
        n_err++;
        $display("FAIL climb_pc: got %h expected %h", bus.pc, exp_pc);
      end
    end
    n_vec++;
    if (bus.pc !== 32'h0000_0020) begin
      n_err++;
      $display("FAIL climb_end: got %h expected 00000020", bus.pc);
    end
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    bus.stall      = 1'b1;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.pc !== RST_PC || bus.instr_valid !== 1'b0 || bus.retired !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: pc=%h valid=%b retired=%0d expected %h 0 0", bus.pc, bus.instr_valid, bus.retired, RST_PC);
    end
    step();
    bus.stall = 1'b0;
    reset     = 1'b0;
    model_pc      = RST_PC;
    model_retired = '0;
    n_vec++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
      n_err++;
      $display("FAIL async_release: req=%b addr=%h expected 1 %h", bus.imem_req, bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    n_vec++;
    if (bus.fetch_err !== 1'b0 || bus.imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_early: err=%b req=%b expected 0 1", bus.fetch_err, bus.imem_req);
    end
    step();
    n_vec++;
    if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.fsm_state !== ST_ERROR) begin
      n_err++;
      $display("FAIL timeout_hit: err=%b req=%b state=%0d expected 1 0 %0d", bus.fetch_err, bus.imem_req, bus.fsm_state, ST_ERROR);
    end
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_sticky: err=%b req=%b valid=%b expected 1 0 0", bus.fetch_err, bus.imem_req, bus.instr_valid);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.fetch_err !== 1'b0 || bus.imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_clear: err=%b req=%b expected 0 1", bus.fetch_err, bus.imem_req);
    end
    step();
    clear_inputs();
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    model_pc      = RST_PC;
    model_retired = '0;
    test_reset();
    test_sequential();
    test_branch_back();
    test_jump_priority();
    test_stall();
    test_wrap();
    test_random();
    test_reset_mid_stall();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
